// File: rtl/baud_gen_frac.sv
// Fractional baud tick generator: a phase accumulator produces an oversample tick
// on each carry, and a small counter turns every OVERSAMPLE of them into a bit tick.
module baud_gen_frac #(
    parameter int unsigned CLK_FREQ   = 32'd100_000_000,
    parameter int unsigned OVERSAMPLE = 32'd8,
    parameter int unsigned ACC_W      = 32'd24,
    parameter int unsigned BAUD0      = 32'd9600,
    parameter int unsigned BAUD1      = 32'd19200,
    parameter int unsigned BAUD2      = 32'd57600,
    parameter int unsigned BAUD3      = 32'd115200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [1:0]                    baud_sel,
    input  logic                          resync,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);

    // Rounded phase increment per clock for a given baud rate.
    function automatic logic [63:0] calc_inc(input logic [63:0] baud);
        calc_inc = (baud * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_FREQ) / 64'd2)
                   / 64'(CLK_FREQ);
    endfunction

    localparam logic [63:0] ACC_MOD = 64'd1 << ACC_W;
    localparam logic [63:0] INC0_W  = calc_inc(64'(BAUD0));
    localparam logic [63:0] INC1_W  = calc_inc(64'(BAUD1));
    localparam logic [63:0] INC2_W  = calc_inc(64'(BAUD2));
    localparam logic [63:0] INC3_W  = calc_inc(64'(BAUD3));

    if (INC0_W == 64'd0 || INC0_W >= ACC_MOD || INC1_W == 64'd0 || INC1_W >= ACC_MOD ||
        INC2_W == 64'd0 || INC2_W >= ACC_MOD || INC3_W == 64'd0 || INC3_W >= ACC_MOD)
    begin : g_bad_inc
        $error("baud_gen_frac: a preset increment is zero or does not fit in ACC_W bits");
    end

    if (OVERSAMPLE < 32'd2 || OVERSAMPLE > 32'd16 ||
        (OVERSAMPLE & (OVERSAMPLE - 32'd1)) != 32'd0)
    begin : g_bad_os
        $error("baud_gen_frac: OVERSAMPLE must be a power of two in 2..16");
    end

    localparam logic [ACC_W-1:0] INC0    = INC0_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC1    = INC1_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC2    = INC2_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC3    = INC3_W[ACC_W-1:0];
    localparam logic [PH_W-1:0]  OS_HALF = PH_W'(OVERSAMPLE / 32'd2);
    localparam logic [PH_W-1:0]  OS_LAST = PH_W'(OVERSAMPLE - 32'd1);
    localparam logic [PH_W-1:0]  OS_ONE  = PH_W'(32'd1);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0] inc_s;
    logic [ACC_W:0]   sum_s;
    logic [PH_W-1:0]  os_cnt_r;
    logic [PH_W-1:0]  os_cnt_s;
    logic [1:0]       sel_r;
    logic [1:0]       sel_s;
    logic             os_tick_r;
    logic             os_tick_s;
    logic             bit_tick_r;
    logic             bit_tick_s;

    // Increment for the committed preset; a differing baud_sel never accumulates.
    always_comb begin
        case (sel_r)
            2'd0:    inc_s = INC0;
            2'd1:    inc_s = INC1;
            2'd2:    inc_s = INC2;
            2'd3:    inc_s = INC3;
            default: inc_s = INC0;
        endcase
    end

    // Next-state: enable, resync and preset change all restart the phase from zero.
    always_comb begin
        sum_s      = {1'b0, acc_r} + {1'b0, inc_s};
        sel_s      = baud_sel;
        acc_s      = {ACC_W{1'b0}};
        os_cnt_s   = {PH_W{1'b0}};
        os_tick_s  = 1'b0;
        bit_tick_s = 1'b0;
        if (!en) begin
            os_cnt_s = {PH_W{1'b0}};
        end else if (resync) begin
            os_cnt_s = OS_HALF;
        end else if (baud_sel != sel_r) begin
            os_cnt_s = {PH_W{1'b0}};
        end else begin
            // The remainder left after a carry is kept so the average rate stays exact.
            acc_s     = sum_s[ACC_W-1:0];
            os_tick_s = sum_s[ACC_W];
            if (sum_s[ACC_W]) begin
                if (os_cnt_r == OS_LAST) begin
                    os_cnt_s   = {PH_W{1'b0}};
                    bit_tick_s = 1'b1;
                end else begin
                    os_cnt_s   = os_cnt_r + OS_ONE;
                    bit_tick_s = 1'b0;
                end
            end else begin
                os_cnt_s   = os_cnt_r;
                bit_tick_s = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r      <= {ACC_W{1'b0}};
            os_cnt_r   <= {PH_W{1'b0}};
            sel_r      <= 2'd0;
            os_tick_r  <= 1'b0;
            bit_tick_r <= 1'b0;
        end else begin
            acc_r      <= acc_s;
            os_cnt_r   <= os_cnt_s;
            sel_r      <= sel_s;
            os_tick_r  <= os_tick_s;
            bit_tick_r <= bit_tick_s;
        end
    end

    assign os_tick  = os_tick_r;
    assign bit_tick = bit_tick_r;
    assign os_phase = os_cnt_r;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac at default parameters: table-driven rate windows, directed
// corner sequences and randomized control traffic against an arithmetic tick model.
module tb_baud_gen_frac;

    localparam int    OS = 8;
    localparam longint M = 64'd16777216;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] baud_sel;
    logic       resync;
    logic       os_tick;
    logic       bit_tick;
    logic [2:0] os_phase;

    baud_gen_frac dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .baud_sel (baud_sel),
        .resync   (resync),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .os_phase (os_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed rounded increments for 9600/19200/57600/115200 x8 at 100 MHz.
    longint inc_ref [4] = '{64'd12885, 64'd25770, 64'd77309, 64'd154619};

    typedef struct {
        logic [1:0] sel;
        int         cycles;
        int         exp_os;
        int         exp_bit;
        int         sp_min;
        int         sp_max;
        int         first;
    } win_t;

    int n_pass;
    int n_checks;

    // Model: ticks = number of multiples of 2^24 crossed by n*INC since the last restart.
    longint m_n;
    int     m_cnt;
    int     m_sel;
    bit     m_os;
    bit     m_bit;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        m_os  = 1'b0;
        m_bit = 1'b0;
        if (!en) begin
            m_n = 0; m_cnt = 0;
        end else if (resync) begin
            m_n = 0; m_cnt = OS / 2;
        end else if (int'(baud_sel) != m_sel) begin
            m_n = 0; m_cnt = 0;
        end else begin
            m_os = (((m_n + 1) * inc_ref[m_sel]) / M) != ((m_n * inc_ref[m_sel]) / M);
            m_n++;
            if (m_os) begin
                m_cnt = (m_cnt + 1) % OS;
                m_bit = (m_cnt == 0);
            end
        end
        m_sel = int'(baud_sel);
        @(posedge clk);
        #1;
        check("model", int'({os_tick, bit_tick, os_phase}), int'({m_os, m_bit, 3'(m_cnt)}));
    endtask

    task automatic wait_os(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (os_tick) begin
                cyc = i;
                break;
            end
        end
    endtask

    win_t tbl [4];
    int   c;
    int   cnt_os, cnt_bit, first, last, sp_min, sp_max, bad;

    initial begin
        tbl[0] = '{2'd0, 12000,  9,  1, 1302, 1303, 1303};
        tbl[1] = '{2'd1,  8000, 12,  1,  651,  652,  652};
        tbl[2] = '{2'd2,  5000, 23,  2,  217,  218,  218};
        tbl[3] = '{2'd3, 10000, 92, 11,  108,  109,  109};
        n_pass = 0; n_checks = 0;
        m_n = 0; m_cnt = 0; m_sel = 0; m_os = 1'b0; m_bit = 1'b0;
        rst = 1'b0; en = 1'b0; baud_sel = 2'd0; resync = 1'b0;

        #3;
        check("reset_state", int'({os_tick, bit_tick, os_phase}), 0);
        @(negedge clk);
        rst = 1'b1;

        // Rate windows: restart, then count ticks, latency and spacing per preset.
        for (int t = 0; t < 4; t++) begin
            en = 1'b0; baud_sel = tbl[t].sel;
            step();
            en = 1'b1;
            cnt_os = 0; cnt_bit = 0; first = -1; last = -1;
            sp_min = 32'h7fffffff; sp_max = 0; bad = 0;
            for (int i = 1; i <= tbl[t].cycles; i++) begin
                step();
                if (bit_tick && !(os_tick && os_phase == 3'd0)) bad++;
                if (os_tick) begin
                    if (first < 0) first = i;
                    else begin
                        if (i - last < sp_min) sp_min = i - last;
                        if (i - last > sp_max) sp_max = i - last;
                    end
                    last = i;
                    cnt_os++;
                    if (bit_tick) cnt_bit++;
                end
            end
            check($sformatf("win%0d_first", t), first, tbl[t].first);
            check($sformatf("win%0d_os_count", t), cnt_os, tbl[t].exp_os);
            check($sformatf("win%0d_bit_count", t), cnt_bit, tbl[t].exp_bit);
            check($sformatf("win%0d_sp_min_ok", t), int'(sp_min >= tbl[t].sp_min), 1);
            check($sformatf("win%0d_sp_max_ok", t), int'(sp_max <= tbl[t].sp_max), 1);
            check($sformatf("win%0d_bit_align", t), bad, 0);
        end

        // Resync at 9600: phase jumps to half-bit, bit tick on the fourth os tick.
        baud_sel = 2'd0;
        repeat (2000) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_phase", int'(os_phase), 4);
        check("resync_no_tick", int'(os_tick), 0);
        wait_os(1400, c);
        check("resync_first_lat", c, 1303);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) wait_os(1400, c);
            check($sformatf("resync_tick%0d_seen", k), c > 0 ? 1 : 0, 1);
            check($sformatf("resync_tick%0d_phase", k), int'(os_phase), (4 + k) % OS);
            check($sformatf("resync_tick%0d_bit", k), int'(bit_tick), k == 4 ? 1 : 0);
        end

        // Preset change mid-bit: quiet switch cycle, then one full 115200 os period.
        repeat (600) step();
        baud_sel = 2'd3;
        step();
        check("sel_switch_no_tick", int'(os_tick), 0);
        check("sel_switch_phase", int'(os_phase), 0);
        wait_os(200, c);
        check("sel_switch_first_lat", c, 109);

        // Resync together with a preset change: one restart only.
        repeat (50) step();
        baud_sel = 2'd1; resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_sel_phase", int'(os_phase), 4);
        wait_os(800, c);
        check("resync_sel_first_lat", c, 652);

        // Disable for 500 cycles, then restart from zero phase.
        repeat (300) step();
        en = 1'b0; baud_sel = 2'd0; bad = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (os_tick || bit_tick || os_phase != 3'd0) bad++;
        end
        check("en_low_idle", bad, 0);
        en = 1'b1;
        wait_os(1400, c);
        check("reenable_first_lat", c, 1303);

        // Asynchronous reset while os_tick is high.
        baud_sel = 2'd3;
        wait_os(250, c);
        check("pre_rst_tick", int'(os_tick), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_clear", int'({os_tick, bit_tick, os_phase}), 0);
        m_n = 0; m_cnt = 0; m_sel = 0;
        baud_sel = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        wait_os(1400, c);
        check("post_rst_first_lat", c, 1303);

        // Randomized enable / resync / preset traffic checked every cycle by the model.
        for (int i = 0; i < 10000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (!en) begin
                if (r < 20) en = 1'b1;
            end else if (r < 3) begin
                en = 1'b0;
            end else if (r < 7) begin
                resync = 1'b1;
            end else if (r < 10) begin
                baud_sel = 2'($urandom_range(1, 3));
            end
            step();
            resync = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
